// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the Execution, Memory and write-back stages.
// Holds the memory-stage FSM state, the zero-register index and the MEM/WB control bundle.
package cpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } dmem_state_t;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic branch;
  } memwb_ctrl_t;

  // A request with both read and write set is handled as a store, so a load needs read without write.
  function automatic logic is_load(input memwb_ctrl_t ctrl);
    return ctrl.mem_read & ~ctrl.mem_write;
  endfunction

endpackage

// File: rtl/dmem_stage_if.sv
// dmem_stage_if: req/ack data-memory bus between the memory stage (master) and the data memory (slave).
// The master holds dmem_req, dmem_we, dmem_addr and dmem_wdata stable until the slave returns dmem_ack.
interface dmem_stage_if #(
  parameter int XLEN = 64
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/dmem_watchdog.sv
// dmem_watchdog: counts cycles spent waiting for a memory ack and flags the last allowed cycle.
// Only instantiated when DMEM_TIMEOUT_EN is defined.
// 'clear' zeroes the count, 'start' lets it advance, 'expired' is high during the
// TIMEOUT_CYCLES-th consecutive cycle of 'start'.
module dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = start & (count == CW'(TIMEOUT_CYCLES - 1));

  // Advance the wait counter while started, holding at the expiry value; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// dmem_stage: LEGv8 memory stage between Execution and write-back.
// Runs one LDUR/STUR over the req/ack bus while stalling Execution, then emits a
// one-cycle write-back record together with the branch decision.
// Optional feature macro: DMEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES
// cycles without ack and pulses bus_err; without it the stage waits forever.
module dmem_stage
  import cpu_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int REG_AW         = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [REG_AW-1:0] rd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              zero,
  input  logic [XLEN-1:0]   branch_target,
  dmem_stage_if.master      dmem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              pc_src,
  output logic [XLEN-1:0]   pc_target,
  output logic              bus_err
);

  dmem_state_t       state;
  memwb_ctrl_t       in_ctrl;
  memwb_ctrl_t       pend_ctrl;
  logic [REG_AW-1:0] pend_rd;
  logic              pend_zero;
  logic [XLEN-1:0]   pend_target;
  logic              req_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;

  assign in_ctrl = '{mem_read:   mem_read,
                     mem_write:  mem_write,
                     mem_to_reg: mem_to_reg,
                     reg_write:  reg_write,
                     branch:     branch};

  assign in_ready        = (state == IDLE);
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

`ifdef DMEM_TIMEOUT_EN
  logic wd_expired;
  logic bus_err_q;

  assign bus_err = bus_err_q;

  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (state == ACCESS),
    .clear  (state == IDLE),
    .expired(wd_expired)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign bus_err            = 1'b0;
`endif

  // Stage FSM: pass non-memory ops straight to write-back, hold memory ops in ACCESS until ack (or timeout).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend_ctrl    <= '0;
      pend_rd      <= '0;
      pend_zero    <= 1'b0;
      pend_target  <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      pc_src       <= 1'b0;
      pc_target    <= '0;
`ifdef DMEM_TIMEOUT_EN
      bus_err_q    <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mem_read || mem_write) begin
              state       <= ACCESS;
              pend_ctrl   <= in_ctrl;
              pend_rd     <= rd;
              pend_zero   <= zero;
              pend_target <= branch_target;
              req_q       <= 1'b1;
              we_q        <= mem_write;
              addr_q      <= alu_result;
              wdata_q     <= store_data;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= reg_write & (rd != REG_AW'(XZR_IDX));
              wb_rd        <= rd;
              wb_data      <= alu_result;
              pc_src       <= branch & zero;
              pc_target    <= branch_target;
            end
          end
        end
        ACCESS: begin
          if (dmem.dmem_ack) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= pend_ctrl.reg_write & (pend_rd != REG_AW'(XZR_IDX));
            wb_rd        <= pend_rd;
            wb_data      <= (pend_ctrl.mem_to_reg && is_load(pend_ctrl)) ? dmem.dmem_rdata : addr_q;
            pc_src       <= pend_ctrl.branch & pend_zero;
            pc_target    <= pend_target;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wd_expired) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= pend_rd;
            wb_data      <= addr_q;
            pc_src       <= 1'b0;
            pc_target    <= pend_target;
            bus_err_q    <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: directed, table-driven bench for dmem_stage.
// Single-cycle ops come from a vector table applied back-to-back; memory accesses,
// stray acks, reset mid-access and the optional timeout are hand-written sequences.
module tb_dmem_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        branch;
  logic        zero;
  logic [63:0] branch_target;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        pc_src;
  logic [63:0] pc_target;
  logic        bus_err;

  int compared;
  int mismatched;

  dmem_stage_if #(.XLEN(64)) bus ();

  dmem_stage #(
    .XLEN(64),
    .REG_AW(5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd           (rd),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .branch       (branch),
    .zero         (zero),
    .branch_target(branch_target),
    .dmem         (bus.master),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .bus_err      (bus_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] alu;
    logic        rw;
    logic        br;
    logic        z;
    logic [63:0] tgt;
    logic        exp_rw;
    logic        exp_pc;
  } vec_t;

  vec_t vecs[6];

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    in_valid      = 1'b0;
    alu_result    = '0;
    store_data    = '0;
    rd            = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    branch        = 1'b0;
    zero          = 1'b0;
    branch_target = '0;
  endtask

  // Drive one record for the next edge (called just after a negedge).
  task automatic applyStimulus(input logic [4:0] r, input logic [63:0] alu, input logic [63:0] sd,
                               input logic mr, input logic mw, input logic m2r, input logic rw,
                               input logic br, input logic z, input logic [63:0] tgt);
    in_valid      = 1'b1;
    rd            = r;
    alu_result    = alu;
    store_data    = sd;
    mem_read      = mr;
    mem_write     = mw;
    mem_to_reg    = m2r;
    reg_write     = rw;
    branch        = br;
    zero          = z;
    branch_target = tgt;
  endtask

  // One memory access: accept, 'waits' cycles without ack, then ack; checks the bus and write-back record.
  task automatic memOp(input string tag, input logic mr, input logic mw, input logic [63:0] addr,
                       input logic [63:0] data, input logic [4:0] r, input logic rw, input logic m2r,
                       input int waits, input logic [63:0] rdata, input logic [63:0] exp_data,
                       input logic exp_rw);
    int req_cycles;
    req_cycles = 0;
    @(negedge clk);
    applyStimulus(r, addr, data, mr, mw, m2r, rw, 1'b0, 1'b0, 64'h0);
    @(posedge clk); #1;
    checkOutput({tag, "_addr"}, bus.dmem_addr, addr);
    checkOutput({tag, "_wdata"}, bus.dmem_wdata, data);
    for (int w = 0; w <= waits; w++) begin
      if (bus.dmem_req) req_cycles++;
      checkOutput({tag, "_in_ready_busy"}, in_ready, 1'b0);
      checkOutput({tag, "_we_hold"}, bus.dmem_we, mw);
      @(negedge clk);
      clearInputs();
      if (w == waits) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end
      @(posedge clk); #1;
    end
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 64'h0;
    checkOutput({tag, "_req_cycles"}, 64'(req_cycles), 64'(waits + 1));
    checkOutput({tag, "_req_drop"}, bus.dmem_req, 1'b0);
    checkOutput({tag, "_we_drop"}, bus.dmem_we, 1'b0);
    checkOutput({tag, "_wb_valid"}, wb_valid, 1'b1);
    checkOutput({tag, "_wb_data"}, wb_data, exp_data);
    checkOutput({tag, "_wb_rd"}, wb_rd, r);
    checkOutput({tag, "_wb_reg_write"}, wb_reg_write, exp_rw);
    checkOutput({tag, "_in_ready_done"}, in_ready, 1'b1);
    @(posedge clk); #1;
    checkOutput({tag, "_wb_valid_pulse"}, wb_valid, 1'b0);
  endtask

  // Main directed sequence.
  initial begin
    compared   = 0;
    mismatched = 0;
    clearInputs();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 64'h0;
    rst_n = 1'b0;

    //            rd     alu                      rw    br    z     tgt        exp_rw exp_pc
    vecs[0] = '{5'd3,  64'h10,                 1'b1, 1'b0, 1'b0, 64'h0,     1'b1,  1'b0};
    vecs[1] = '{5'd31, 64'h77,                 1'b1, 1'b0, 1'b0, 64'h0,     1'b0,  1'b0};
    vecs[2] = '{5'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 64'h200,   1'b0,  1'b1};
    vecs[3] = '{5'd0,  64'h5,                  1'b0, 1'b1, 1'b0, 64'h300,   1'b0,  1'b0};
    vecs[4] = '{5'd7,  64'hABCD,               1'b0, 1'b0, 1'b1, 64'h40,    1'b0,  1'b0};
    vecs[5] = '{5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8,    1'b1,  1'b0};

    // Reset values while held in reset.
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_wb_valid", wb_valid, 1'b0);
    checkOutput("rst_wb_reg_write", wb_reg_write, 1'b0);
    checkOutput("rst_wb_rd", wb_rd, 5'd0);
    checkOutput("rst_wb_data", wb_data, 64'h0);
    checkOutput("rst_pc_src", pc_src, 1'b0);
    checkOutput("rst_pc_target", pc_target, 64'h0);
    checkOutput("rst_dmem_req", bus.dmem_req, 1'b0);
    checkOutput("rst_dmem_we", bus.dmem_we, 1'b0);
    checkOutput("rst_dmem_addr", bus.dmem_addr, 64'h0);
    checkOutput("rst_dmem_wdata", bus.dmem_wdata, 64'h0);
    checkOutput("rst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops from the vector table.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].rd, vecs[i].alu, 64'h0, 1'b0, 1'b0, 1'b0, vecs[i].rw,
                    vecs[i].br, vecs[i].z, vecs[i].tgt);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_wb_valid", i), wb_valid, 1'b1);
      checkOutput($sformatf("vec%0d_wb_rd", i), wb_rd, vecs[i].rd);
      checkOutput($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].alu);
      checkOutput($sformatf("vec%0d_wb_reg_write", i), wb_reg_write, vecs[i].exp_rw);
      checkOutput($sformatf("vec%0d_pc_src", i), pc_src, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d_pc_target", i), pc_target, vecs[i].tgt);
      checkOutput($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      checkOutput($sformatf("vec%0d_req", i), bus.dmem_req, 1'b0);
    end
    @(negedge clk);
    clearInputs();
    @(posedge clk); #1;
    checkOutput("idle_wb_valid", wb_valid, 1'b0);

    // LDUR with three wait states, STUR with zero wait states, load to XZR, read+write treated as store.
    memOp("ldur", 1'b1, 1'b0, 64'h40, 64'h0,  5'd5,  1'b1, 1'b1, 3, 64'hDEAD, 64'hDEAD, 1'b1);
    memOp("stur", 1'b0, 1'b1, 64'h8,  64'h55, 5'd0,  1'b0, 1'b0, 0, 64'h1234, 64'h8,    1'b0);
    memOp("ldxzr", 1'b1, 1'b0, 64'h20, 64'h0, 5'd31, 1'b1, 1'b1, 1, 64'hCAFE, 64'hCAFE, 1'b0);
    memOp("rdwr", 1'b1, 1'b1, 64'h18, 64'h99, 5'd9,  1'b1, 1'b1, 2, 64'hBEEF, 64'h18,   1'b1);

    // Ack with no request outstanding does nothing.
    @(negedge clk);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 64'hFF;
    @(posedge clk); #1;
    checkOutput("stray_ack_wb_valid", wb_valid, 1'b0);
    checkOutput("stray_ack_in_ready", in_ready, 1'b1);
    checkOutput("stray_ack_req", bus.dmem_req, 1'b0);
    @(negedge clk);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 64'h0;

    // Reset in the middle of an access drops the request immediately.
    @(negedge clk);
    applyStimulus(5'd4, 64'h80, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    @(posedge clk); #1;
    checkOutput("rstmid_req_before", bus.dmem_req, 1'b1);
    @(negedge clk);
    clearInputs();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_req_now", bus.dmem_req, 1'b0);
    checkOutput("rstmid_in_ready_now", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmid_in_ready_after", in_ready, 1'b1);
    checkOutput("rstmid_wb_valid_after", wb_valid, 1'b0);
    @(negedge clk);
    applyStimulus(5'd12, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    @(posedge clk); #1;
    checkOutput("rstmid_next_wb_data", wb_data, 64'h1234);
    checkOutput("rstmid_next_wb_valid", wb_valid, 1'b1);
    @(negedge clk);
    clearInputs();

`ifdef DMEM_TIMEOUT_EN
    // Load with no ack: request held four cycles, then abort with bus_err.
    @(negedge clk);
    applyStimulus(5'd6, 64'h100, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("to_req_c%0d", c), bus.dmem_req, 1'b1);
      checkOutput($sformatf("to_bus_err_c%0d", c), bus_err, 1'b0);
      @(negedge clk);
      clearInputs();
    end
    @(posedge clk); #1;
    checkOutput("to_req_drop", bus.dmem_req, 1'b0);
    checkOutput("to_wb_valid", wb_valid, 1'b1);
    checkOutput("to_wb_reg_write", wb_reg_write, 1'b0);
    checkOutput("to_bus_err", bus_err, 1'b1);
    checkOutput("to_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    checkOutput("to_bus_err_pulse", bus_err, 1'b0);
    checkOutput("to_wb_valid_pulse", wb_valid, 1'b0);

    // Ack arriving in the timeout cycle wins.
    memOp("to_ack_wins", 1'b1, 1'b0, 64'h110, 64'h0, 5'd7, 1'b1, 1'b1, 3, 64'h7777, 64'h7777, 1'b1);
    checkOutput("to_ack_wins_bus_err", bus_err, 1'b0);
`else
    checkOutput("no_timeout_bus_err", bus_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
